// File: rtl/walk_phase_ctrl.sv
// walk_phase_ctrl: consumer end of the walk-request interface and sequencer
// for the pedestrian phase (WALK, optional flashing DONT_WALK, hand back).
//
// The main FSM offers a slot with a level handshake on Walk_Slot. If a walk
// request is latched, the request register is cleared with a one-cycle
// WR_Reset pulse. The walk phase is then timed from the 1 Hz enable. If no
// request is latched, the slot is skipped at once. Either way Walk_Done pulses
// for one cycle, and Walk_Served says whether a walk phase actually ran.
//
// Build option: define WALK_FLASH_EN to include the flashing DONT_WALK
// interval (FLASH state and flash bit). When it is undefined, WALK goes
// straight to DONE and DONT_WALK is lit whenever WALK is dark.
//
// Parameters:
//   WALK_SEC   1 Hz ticks with the Walk lamp lit (>=1)
//   FLASH_SEC  1 Hz ticks of flashing DONT_WALK (>=1, unused without flash)
// Ports:
//   clk            system clock, rising edge
//   Reset_Sync     synchronous active-high reset
//   Expired_1Hz    one-cycle 1 Hz enable pulse
//   WR             latched walk request (level)
//   Walk_Slot      walk slot offered by main FSM (level until Walk_Done)
//   WR_Reset       one-cycle clear pulse to the walk-request register
//   Walk_Lamp      pedestrian WALK lamp
//   DontWalk_Lamp  pedestrian DONT_WALK lamp
//   Walk_Done      one-cycle pulse: slot finished
//   Walk_Served    qualifies Walk_Done: 1 = phase ran, 0 = slot skipped
module walk_phase_ctrl #(
    parameter int WALK_SEC  = 3,
    parameter int FLASH_SEC = 2
) (
    input  logic clk,
    input  logic Reset_Sync,
    input  logic Expired_1Hz,
    input  logic WR,
    input  logic Walk_Slot,
    output logic WR_Reset,
    output logic Walk_Lamp,
    output logic DontWalk_Lamp,
    output logic Walk_Done,
    output logic Walk_Served
);

    localparam int MAX_SEC = (WALK_SEC > FLASH_SEC) ? WALK_SEC : FLASH_SEC;
    localparam int CW      = $clog2(MAX_SEC + 1);

`ifdef WALK_FLASH_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SKIP, S_GRANT, S_WALK, S_FLASH, S_DONE, S_RELEASE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SKIP, S_GRANT, S_WALK, S_DONE, S_RELEASE
    } state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

`ifdef WALK_FLASH_EN
    logic flash, flash_n;
`endif

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state <= S_IDLE;
            cnt   <= '0;
`ifdef WALK_FLASH_EN
            flash <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
`ifdef WALK_FLASH_EN
            flash <= flash_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
`ifdef WALK_FLASH_EN
        flash_n = flash;
`endif
        case (state)
            S_IDLE: begin
                if (Walk_Slot)
                    state_n = WR ? S_GRANT : S_SKIP;
            end
            S_SKIP: state_n = S_RELEASE;
            S_GRANT: begin
                // A tick landing in this cycle is deliberately not counted.
                cnt_n   = CW'(WALK_SEC);
                state_n = S_WALK;
            end
            S_WALK: begin
                if (Expired_1Hz) begin
                    if (cnt == CW'(1)) begin
`ifdef WALK_FLASH_EN
                        state_n = S_FLASH;
                        cnt_n   = CW'(FLASH_SEC);
                        flash_n = 1'b1;
`else
                        state_n = S_DONE;
                        cnt_n   = '0;
`endif
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
            end
`ifdef WALK_FLASH_EN
            S_FLASH: begin
                if (Expired_1Hz) begin
                    flash_n = ~flash;
                    if (cnt == CW'(1)) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
            end
`endif
            S_DONE: state_n = S_RELEASE;
            // Hold until the offer is withdrawn so one offer yields one service.
            S_RELEASE: begin
                if (!Walk_Slot)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Moore outputs: decoded from registered state only.
    always_comb begin
        WR_Reset      = (state == S_GRANT);
        Walk_Lamp     = (state == S_WALK);
        Walk_Done     = (state == S_SKIP) || (state == S_DONE);
        Walk_Served   = (state == S_DONE);
`ifdef WALK_FLASH_EN
        DontWalk_Lamp = (state == S_FLASH) ? flash : (state != S_WALK);
`else
        DontWalk_Lamp = (state != S_WALK);
`endif
    end

endmodule

// File: tb/tb_walk_phase_ctrl.sv
module tb_walk_phase_ctrl;

    localparam int WS = 3;
    localparam int FS = 2;
    localparam int L  = 4000;
    localparam int NONE = 1000000;

    logic clk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, wr = 1'b0, slot = 1'b0;
    logic wrr, walk, dw, done, srv;

    int n_tests = 0;
    int n_fail  = 0;

    walk_phase_ctrl #(.WALK_SEC(WS), .FLASH_SEC(FS)) dut (
        .clk(clk), .Reset_Sync(rst), .Expired_1Hz(tick), .WR(wr), .Walk_Slot(slot),
        .WR_Reset(wrr), .Walk_Lamp(walk), .DontWalk_Lamp(dw),
        .Walk_Done(done), .Walk_Served(srv)
    );

    always #5 clk = ~clk;

    // Per-cycle stimulus, expected and observed timelines.
    bit s_rst[L], s_tick[L], s_wr[L], s_slot[L];
    bit e_wrr[L], e_walk[L], e_dw[L], e_done[L], e_srv[L];
    bit o_wrr[L], o_walk[L], o_dw[L], o_done[L], o_srv[L];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < L; k++) begin
            s_rst[k] = 0; s_tick[k] = 0; s_wr[k] = 0; s_slot[k] = 0;
        end
    endtask

    function automatic int nth_tick(int from, int n, int len);
        int seen = 0;
        for (int k = from; k < len; k++)
            if (s_tick[k]) begin
                seen++;
                if (seen == n) return k;
            end
        return NONE;
    endfunction

    function automatic int count_ticks(int a, int b);
        int n = 0;
        for (int k = a; k <= b; k++) if (s_tick[k]) n++;
        return n;
    endfunction

    function automatic int first_rst(int from, int len);
        for (int k = from; k < len; k++) if (s_rst[k]) return k;
        return NONE;
    endfunction

    function automatic int first_low(int from, int len);
        for (int k = from; k < len; k++) if (!s_slot[k]) return k;
        return NONE;
    endfunction

    // Timeline model: at an idle decision cycle c, compute where the grant,
    // walk interval, flash interval and done pulse fall by counting ticks in
    // the stimulus, then truncate the whole service at the first reset.
    task automatic build_model(input int len);
        int c, rr, g, wend, fend, d, e, nxt;
        bit served;
        for (int k = 0; k < L; k++) begin
            e_wrr[k] = 0; e_walk[k] = 0; e_dw[k] = 1; e_done[k] = 0; e_srv[k] = 0;
        end
        c = 0;
        while (c < len) begin
            if (s_rst[c] || !s_slot[c]) begin
                c++;
                continue;
            end
            rr     = first_rst(c, len);
            served = s_wr[c];
            g      = c + 1;
            wend   = g;
            fend   = g;
            if (served) begin
                wend = nth_tick(g + 1, WS, len);
`ifdef WALK_FLASH_EN
                fend = (wend >= NONE) ? NONE : nth_tick(wend + 1, FS, len);
`else
                fend = wend;
`endif
                d = (fend >= NONE) ? NONE : fend + 1;
            end else begin
                d = c + 1;
            end
            e   = (d >= NONE) ? NONE : first_low(d + 1, len) + 1;
            nxt = (rr + 1 < e) ? rr + 1 : e;
            for (int k = c + 1; k < nxt && k < len; k++) begin
                if (served && k == g) begin
                    e_wrr[k] = 1;
                end else if (served && k <= wend) begin
                    e_walk[k] = 1; e_dw[k] = 0;
                end else if (served && k <= fend) begin
                    e_dw[k] = (count_ticks(wend + 1, k - 1) % 2 == 0);
                end else if (k == d) begin
                    e_done[k] = 1; e_srv[k] = served;
                end
            end
            c = nxt;
        end
    endtask

    // Outputs are sampled 1 time unit after the edge (state from the previous
    // cycle's inputs); then this cycle's inputs are driven.
    task automatic run_seq(input string tag, input int len);
        build_model(len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            o_wrr[c] = wrr; o_walk[c] = walk; o_dw[c] = dw; o_done[c] = done; o_srv[c] = srv;
            if (c > 0) begin
                n_tests++;
                if ({wrr, walk, dw, done, srv} !==
                    {e_wrr[c], e_walk[c], e_dw[c], e_done[c], e_srv[c]}) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got wrr/walk/dw/done/srv=%b%b%b%b%b expected %b%b%b%b%b",
                             tag, c, wrr, walk, dw, done, srv,
                             e_wrr[c], e_walk[c], e_dw[c], e_done[c], e_srv[c]);
                end
                if (walk && dw) chk({tag, " lamps_both_on"}, 1, 0);
            end
            rst = s_rst[c]; tick = s_tick[c]; wr = s_wr[c]; slot = s_slot[c];
        end
    endtask

    typedef struct {
        bit       rst, tick, wr, slot, chk;
        bit [4:0] exp;   // {WR_Reset, Walk_Lamp, DontWalk_Lamp, Walk_Done, Walk_Served}
    } tv_t;

    tv_t tv[14];

    initial begin
        int n_wrr, n_done;
        bit any_done;

        tv[0]  = '{1, 0, 1, 1, 0, 5'b00100};
        tv[1]  = '{1, 0, 1, 1, 1, 5'b00100};  // held in reset despite slot+request
        tv[2]  = '{0, 0, 1, 1, 1, 5'b00100};
        tv[3]  = '{0, 0, 1, 1, 1, 5'b10100};  // GRANT right after reset drops
        tv[4]  = '{0, 0, 0, 1, 1, 5'b01000};  // WALK
        tv[5]  = '{1, 0, 0, 1, 1, 5'b01000};
        tv[6]  = '{0, 0, 0, 1, 1, 5'b00100};  // reset mid-walk: back to DONT_WALK
        tv[7]  = '{0, 0, 0, 1, 1, 5'b00110};  // skip: done, not served
        tv[8]  = '{0, 0, 1, 1, 1, 5'b00100};  // release ignores new request
        tv[9]  = '{0, 0, 1, 0, 1, 5'b00100};
        tv[10] = '{0, 0, 0, 0, 1, 5'b00100};  // idle; WR falling with no slot
        tv[11] = '{0, 0, 0, 0, 1, 5'b00100};
        tv[12] = '{0, 0, 0, 1, 1, 5'b00100};
        tv[13] = '{0, 0, 0, 0, 1, 5'b00110};

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (tv[i].chk) chk($sformatf("vec%0d", i), {wrr, walk, dw, done, srv}, tv[i].exp);
            rst = tv[i].rst; tick = tv[i].tick; wr = tv[i].wr; slot = tv[i].slot;
        end

        // Full phase, ticks every 10 cycles, slot held after Walk_Done with a
        // re-pressed request, then a fresh offer.
        clear_stim();
        for (int k = 0; k < 200; k++) begin
            s_rst[k]  = (k < 2);
            s_tick[k] = (k > 0) && (k % 10 == 0);
            s_slot[k] = (k < 100) || (k >= 105 && k < 170);
            s_wr[k]   = (k <= 3) || (k >= 35 && k <= 106);
        end
        run_seq("phase", 200);
        n_wrr = 0; n_done = 0;
        for (int k = 1; k < 200; k++) begin
            n_wrr  += o_wrr[k];
            n_done += o_done[k];
        end
        chk("wr_reset_at_N+1", o_wrr[3], 1);
        chk("wr_reset_pulses", n_wrr, 2);
        chk("walk_from_N+2", o_walk[4], 1);
        chk("walk_through_3rd_tick", o_walk[30], 1);
        chk("walk_off_after_3rd_tick", o_walk[31], 0);
        chk("done_pulses", n_done, 2);
        chk("no_service_while_held", o_done[90] | o_wrr[90], 0);
        chk("second_grant", o_wrr[106], 1);
`ifdef WALK_FLASH_EN
        chk("flash_dw_first", o_dw[35], 1);
        chk("flash_dw_second", o_dw[45], 0);
        chk("done_served", {o_done[51], o_srv[51]}, 2'b11);
`else
        chk("dw_after_walk", o_dw[31], 1);
        chk("done_served", {o_done[31], o_srv[31]}, 2'b11);
`endif

        // Reset during the second walk second.
        clear_stim();
        for (int k = 0; k < 60; k++) begin
            s_rst[k]  = (k == 0) || (k == 15);
            s_tick[k] = (k > 0) && (k % 10 == 0);
            s_slot[k] = (k >= 2 && k < 15);
            s_wr[k]   = (k <= 3);
        end
        run_seq("midreset", 60);
        any_done = 0;
        for (int k = 1; k < 60; k++) any_done |= o_done[k];
        chk("walk_before_reset", o_walk[15], 1);
        chk("lamps_after_reset", {o_walk[16], o_dw[16]}, 2'b01);
        chk("no_done_after_reset", any_done, 0);

        // Randomized traffic against the timeline model.
        clear_stim();
        begin
            bit sl = 0, w = 0;
            for (int k = 0; k < L; k++) begin
                if ($urandom_range(0, 24) == 0) sl = ~sl;
                if ($urandom_range(0, 14) == 0) w = ~w;
                s_rst[k]  = (k == 0) || ($urandom_range(0, 399) == 0);
                s_tick[k] = ($urandom_range(0, 5) == 0);
                s_slot[k] = sl;
                s_wr[k]   = w;
            end
        end
        run_seq("random", L);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
